// File: rtl/dsi_rx_pkg.sv
// Shared types and helpers for the DSI receive lane merger.
//  lane_cfg_e      : active lane count encoding (cfg_lanes)
//  parser_state_e  : packet parser states
//  HdrOff*         : byte offsets of the header fields within a packet header
//  is_long_dt()    : true for long-packet data types
//  dsi_ecc()       : 6-bit DSI Hamming ECC over the 24 header data bits
package dsi_rx_pkg;

  typedef enum logic [1:0] {
    Lanes1 = 2'd0,
    Lanes2 = 2'd1,
    Lanes3 = 2'd2,
    Lanes4 = 2'd3
  } lane_cfg_e;

  typedef enum logic [1:0] {
    StHdr     = 2'd0,
    StPayload = 2'd1,
    StCrc     = 2'd2
  } parser_state_e;

  localparam logic [1:0] HdrOffDi  = 2'd0;
  localparam logic [1:0] HdrOffB1  = 2'd1;
  localparam logic [1:0] HdrOffB2  = 2'd2;
  localparam logic [1:0] HdrOffEcc = 2'd3;

  function automatic logic is_long_dt(input logic [5:0] dt);
    logic long_dt;
    case (dt[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: long_dt = 1'b1;
      default:                long_dt = 1'b0;
    endcase
    return long_dt;
  endfunction

  // d = {b2, b1, DI}; each parity bit is the XOR of the data bits selected by its mask.
  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

endpackage

// File: rtl/lane_merger_fifo.sv
// Byte FIFO for the lane merger: writes 1..4 bytes per cycle, reads 1 byte per cycle.
// The caller guarantees no overflow (checks o_count) and no read when empty.
//  i_clk, i_rst : clock, synchronous active-high reset (flushes the FIFO)
//  i_wr_en      : write i_wr_n bytes from i_wr_data, byte 0 = i_wr_data[7:0] first
//  i_rd_en      : pop the byte shown on o_rd_data
//  o_count      : bytes currently stored; o_empty when zero
module lane_merger_fifo #(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_en,
  input  logic [2:0]                    i_wr_n,
  input  logic [31:0]                   i_wr_data,
  input  logic                          i_rd_en,
  output logic [7:0]                    o_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_empty
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (3'(i) < i_wr_n) begin
          r_mem[r_wr_ptr + AddrW'(i)] <= i_wr_data[8*i +: 8];
        end
      end
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + AddrW'(i_wr_n);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + AddrW'(1);
      r_count <= r_count + (i_wr_en ? CntW'(i_wr_n) : '0) - CntW'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/lane_merger.sv
// DSI receive lane merger: captures bytes from up to four PPI lanes (lane0 first), buffers them
// and parses the byte stream into packet header, payload (valid/ready) and CRC.
// Optional feature macro: LANE_MERGER_ECC_CHECK_EN enables the header ECC check; when undefined
// hdr_ecc_err is tied to 0.
//  dsi_clk, dsi_rst        : clock, synchronous active-high reset
//  cfg_lanes               : active lanes - 1, sampled on the first beat of a burst
//  ppi_lane_en[0]          : frames a burst; each high cycle is one beat
//  ppi_data_lane0..3       : lane bytes
//  hdr_valid/di/wc/ecc_err : header pulse and fields
//  pl_data/valid/ready/last: payload stream
//  crc_valid/crc_rx        : received checksum pulse {hi,lo}
//  trunc_err, rx_done      : end-of-burst status pulses; ovf_err sticky beat-drop flag
module lane_merger
  import dsi_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        dsi_clk,
  input  logic        dsi_rst,
  input  logic [1:0]  cfg_lanes,
  input  logic [3:0]  ppi_lane_en,
  input  logic [7:0]  ppi_data_lane0,
  input  logic [7:0]  ppi_data_lane1,
  input  logic [7:0]  ppi_data_lane2,
  input  logic [7:0]  ppi_data_lane3,
  output logic        hdr_valid,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic        hdr_ecc_err,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic        pl_last,
  output logic        crc_valid,
  output logic [15:0] crc_rx,
  output logic        trunc_err,
  output logic        ovf_err,
  output logic        rx_done
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            r_en0;
  lane_cfg_e       r_lanes;
  lane_cfg_e       w_lanes;
  logic            w_first;
  logic [2:0]      w_n;
  logic [CntW-1:0] w_count;
  logic [CntW-1:0] w_free;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_empty;
  logic [7:0]      w_rd_byte;
  logic            w_unused_en;

  // ---------------- capture ----------------
  assign w_first = ppi_lane_en[0] & ~r_en0;
  assign w_lanes = w_first ? lane_cfg_e'(cfg_lanes) : r_lanes;
  assign w_n     = {1'b0, w_lanes} + 3'd1;
  // Free space is taken before this cycle's pop; a beat that does not fit is dropped whole.
  assign w_free  = CntW'(FIFO_DEPTH) - w_count;
  assign w_wr_en = ppi_lane_en[0] & (w_free >= CntW'(w_n));
  assign w_unused_en = ^ppi_lane_en[3:1];

  always_ff @(posedge dsi_clk) begin
    if (dsi_rst) begin
      r_en0   <= 1'b0;
      r_lanes <= Lanes1;
      ovf_err <= 1'b0;
    end else begin
      r_en0 <= ppi_lane_en[0];
      if (w_first) r_lanes <= lane_cfg_e'(cfg_lanes);
      if (ppi_lane_en[0] && !w_wr_en) ovf_err <= 1'b1;
    end
  end

  lane_merger_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (dsi_clk),
    .i_rst     (dsi_rst),
    .i_wr_en   (w_wr_en),
    .i_wr_n    (w_n),
    .i_wr_data ({ppi_data_lane3, ppi_data_lane2, ppi_data_lane1, ppi_data_lane0}),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_rd_byte),
    .o_count   (w_count),
    .o_empty   (w_empty)
  );

  // ---------------- parser ----------------
  parser_state_e r_state;
  logic [1:0]    r_hcnt;
  logic [7:0]    r_di;
  logic [7:0]    r_b1;
  logic [7:0]    r_b2;
  logic [15:0]   r_remain;
  logic [7:0]    r_crc_lo;
  logic          r_crc_hi;
  logic          r_pend;

  always_comb begin
    w_rd_en = 1'b0;
    unique case (r_state)
      StHdr, StCrc: w_rd_en = ~w_empty;
      StPayload:    w_rd_en = ~w_empty & pl_ready;
      default:      w_rd_en = 1'b0;
    endcase
  end

  assign pl_valid = (r_state == StPayload) & ~w_empty;
  assign pl_data  = pl_valid ? w_rd_byte : 8'h00;
  assign pl_last  = pl_valid & (r_remain == 16'd1);

  always_ff @(posedge dsi_clk) begin
    if (dsi_rst) begin
      r_state     <= StHdr;
      r_hcnt      <= 2'd0;
      r_di        <= 8'h00;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
      r_remain    <= 16'd0;
      r_crc_lo    <= 8'h00;
      r_crc_hi    <= 1'b0;
      r_pend      <= 1'b0;
      hdr_valid   <= 1'b0;
      hdr_di      <= 8'h00;
      hdr_wc      <= 16'h0000;
      hdr_ecc_err <= 1'b0;
      crc_valid   <= 1'b0;
      crc_rx      <= 16'h0000;
      trunc_err   <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      crc_valid <= 1'b0;
      trunc_err <= 1'b0;
      rx_done   <= 1'b0;

      unique case (r_state)
        StHdr: begin
          if (w_rd_en) begin
            r_hcnt <= r_hcnt + 2'd1;
            unique case (r_hcnt)
              HdrOffDi: r_di <= w_rd_byte;
              HdrOffB1: r_b1 <= w_rd_byte;
              HdrOffB2: r_b2 <= w_rd_byte;
              HdrOffEcc: begin
                hdr_valid <= 1'b1;
                hdr_di    <= r_di;
                hdr_wc    <= {r_b2, r_b1};
`ifdef LANE_MERGER_ECC_CHECK_EN
                hdr_ecc_err <= (dsi_ecc({r_b2, r_b1, r_di}) != w_rd_byte[5:0]);
`else
                hdr_ecc_err <= 1'b0;
`endif
                r_remain <= {r_b2, r_b1};
                if (is_long_dt(r_di[5:0])) begin
                  r_state <= ({r_b2, r_b1} == 16'd0) ? StCrc : StPayload;
                end
              end
              default: ;
            endcase
          end
        end
        StPayload: begin
          if (w_rd_en) begin
            r_remain <= r_remain - 16'd1;
            if (r_remain == 16'd1) r_state <= StCrc;
          end
        end
        StCrc: begin
          if (w_rd_en) begin
            if (!r_crc_hi) begin
              r_crc_lo <= w_rd_byte;
              r_crc_hi <= 1'b1;
            end else begin
              crc_valid <= 1'b1;
              crc_rx    <= {w_rd_byte, r_crc_lo};
              r_crc_hi  <= 1'b0;
              r_state   <= StHdr;
            end
          end
        end
        default: r_state <= StHdr;
      endcase

      // End-of-burst check: armed on the falling edge of lane-0 enable, disarmed by a new
      // burst, resolved once the FIFO has drained (no pop can happen while empty).
      if (ppi_lane_en[0]) begin
        r_pend <= 1'b0;
      end else if (r_en0) begin
        r_pend <= 1'b1;
      end else if (r_pend && w_empty) begin
        r_pend <= 1'b0;
        if (r_state == StHdr && r_hcnt == 2'd0) begin
          rx_done <= 1'b1;
        end else begin
          trunc_err <= 1'b1;
          r_state   <= StHdr;
          r_hcnt    <= 2'd0;
          r_crc_hi  <= 1'b0;
        end
      end
    end
  end

endmodule
